// File: rtl/scroll_pkg.sv
// Shared constants and state encoding for the 4-digit scrolling-message controller.
package scroll_pkg;

  localparam int unsigned DIG_W      = 8;
  localparam int unsigned LEN_W      = 5;
  localparam int unsigned NUM_DIGITS = 4;

  // Active-low segment patterns: a 1 turns the segment off.
  localparam logic [DIG_W-1:0] SEG_BLANK = 8'hFF;
  localparam logic [DIG_W-1:0] SEG_o     = 8'b01000111;
  localparam logic [DIG_W-1:0] SEG_L     = 8'b10001111;

  typedef enum logic [2:0] {
    ST_EMPTY,
    ST_STATIC,
    ST_SCROLL,
    ST_PREVIEW,
    ST_PEEK,
    ST_CLEAR
  } state_e;

endpackage

// File: rtl/scroll_tick_gen.sv
// Enable-gated scroll-step divider; emits a 1-cycle tick every TICK_DIV enabled cycles.
module scroll_tick_gen #(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned         CNT_W   = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = en && (cnt == CNT_MAX);

endmodule

// File: rtl/scroll_sequencer.sv
// Stores switch-entered segment patterns and sequences them onto four digit
// registers as preview/peek, right-aligned static text or a circular scroll.
module scroll_sequencer
  import scroll_pkg::*;
#(
  parameter int unsigned MSG_DEPTH = 20,
  parameter int unsigned TICK_DIV  = 25000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_load,
  input  logic             btn_peek,
  input  logic             btn_clear,
  input  logic [7:0]       sw,
  output logic [7:0]       dig1,
  output logic [7:0]       dig2,
  output logic [7:0]       dig3,
  output logic [7:0]       dig4,
  output logic [LEN_W-1:0] msg_len,
  output logic             full,
  output logic             scrolling
);

  state_e           state;
  logic             load_q;
  logic [LEN_W-1:0] pos;
  logic [DIG_W-1:0] msg_buf [MSG_DEPTH];
  logic [DIG_W-1:0] win_c [NUM_DIGITS];
  logic             tick;
  logic             load_rise_c;

  assign load_rise_c = btn_load && !load_q;

  // Step counter runs only while the registered state is SCROLL.
  scroll_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (scrolling),
    .tick  (tick)
  );

  // Run-mode digit window: scroll stream is buf[0..len-1] plus one trailing blank.
  always_comb begin
    for (int j = 0; j < int'(NUM_DIGITS); j++) begin
      logic [LEN_W:0] idx;
      idx      = '0;
      win_c[j] = SEG_BLANK;
      if (msg_len >= LEN_W'(5)) begin
        idx = (LEN_W+1)'(pos) + (LEN_W+1)'(j);
        if (idx > (LEN_W+1)'(msg_len)) begin
          idx = idx - (LEN_W+1)'(msg_len) - (LEN_W+1)'(1);
        end
        if (idx != (LEN_W+1)'(msg_len)) begin
          win_c[j] = msg_buf[idx[LEN_W-1:0]];
        end
      end else if ((LEN_W+1)'(msg_len) + (LEN_W+1)'(j) >= (LEN_W+1)'(NUM_DIGITS)) begin
        idx      = (LEN_W+1)'(msg_len) + (LEN_W+1)'(j) - (LEN_W+1)'(NUM_DIGITS);
        win_c[j] = msg_buf[idx[LEN_W-1:0]];
      end
    end
  end

  // Button priority clear > load > peek > run; every output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      load_q    <= 1'b0;
      pos       <= '0;
      msg_len   <= '0;
      full      <= 1'b0;
      scrolling <= 1'b0;
      dig1      <= SEG_BLANK;
      dig2      <= SEG_BLANK;
      dig3      <= SEG_BLANK;
      dig4      <= SEG_BLANK;
      for (int i = 0; i < int'(MSG_DEPTH); i++) begin
        msg_buf[i] <= SEG_BLANK;
      end
    end else begin
      load_q <= btn_load;
      if (btn_clear) begin
        state     <= ST_CLEAR;
        pos       <= '0;
        msg_len   <= '0;
        full      <= 1'b0;
        scrolling <= 1'b0;
        dig1      <= SEG_BLANK;
        dig2      <= SEG_BLANK;
        dig3      <= SEG_BLANK;
        dig4      <= SEG_BLANK;
        for (int i = 0; i < int'(MSG_DEPTH); i++) begin
          msg_buf[i] <= SEG_BLANK;
        end
      end else if (btn_load) begin
        state     <= ST_PREVIEW;
        pos       <= '0;
        scrolling <= 1'b0;
        dig1      <= SEG_o;
        dig2      <= SEG_BLANK;
        dig3      <= SEG_BLANK;
        dig4      <= ~sw;
        if (load_rise_c && !full) begin
          msg_buf[msg_len] <= ~sw;
          msg_len          <= msg_len + LEN_W'(1);
          full             <= (msg_len + LEN_W'(1)) == LEN_W'(MSG_DEPTH);
        end
      end else if (btn_peek) begin
        state     <= ST_PEEK;
        pos       <= '0;
        scrolling <= 1'b0;
        dig1      <= SEG_L;
        dig2      <= SEG_BLANK;
        dig3      <= SEG_BLANK;
        dig4      <= ~sw;
      end else begin
        dig1 <= win_c[0];
        dig2 <= win_c[1];
        dig3 <= win_c[2];
        dig4 <= win_c[3];
        if (msg_len == '0) begin
          state     <= ST_EMPTY;
          pos       <= '0;
          scrolling <= 1'b0;
        end else if (msg_len < LEN_W'(5)) begin
          state     <= ST_STATIC;
          pos       <= '0;
          scrolling <= 1'b0;
        end else begin
          state     <= ST_SCROLL;
          scrolling <= 1'b1;
          if (state == ST_SCROLL && tick) begin
            pos <= (pos == msg_len) ? '0 : pos + LEN_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_scroll_sequencer.sv
// Randomised and directed bench for scroll_sequencer against a queue-based message model.
module tb_scroll_sequencer;

  localparam int unsigned MSG_DEPTH = 20;
  localparam int unsigned TICK_DIV  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_load, btn_peek, btn_clear;
  logic [7:0] sw;
  logic [7:0] dig1, dig2, dig3, dig4;
  logic [4:0] msg_len;
  logic       full, scrolling;

  always #5 clk = ~clk;

  scroll_sequencer #(
    .MSG_DEPTH (MSG_DEPTH),
    .TICK_DIV  (TICK_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_load  (btn_load),
    .btn_peek  (btn_peek),
    .btn_clear (btn_clear),
    .sw        (sw),
    .dig1      (dig1),
    .dig2      (dig2),
    .dig3      (dig3),
    .dig4      (dig4),
    .msg_len   (msg_len),
    .full      (full),
    .scrolling (scrolling)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: message as a queue, scroll position and cycles spent scrolling.
  logic [7:0] m_q [$];
  logic       m_load_prev;
  bit         m_scroll;
  int         m_pos;
  int         m_age;
  logic [7:0] m_dig [4];

  function automatic logic [7:0] m_char(input int k);
    int len = m_q.size();
    int s;
    if (len == 0) return 8'hFF;
    if (len <= 4) begin
      s = len - (5 - k);
      return (s < 0) ? 8'hFF : m_q[s];
    end
    s = (m_pos + k - 1) % (len + 1);
    return (s == len) ? 8'hFF : m_q[s];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_load_prev = 1'b0;
    m_scroll    = 1'b0;
    m_pos       = 0;
    m_age       = 0;
    for (int k = 0; k < 4; k++) m_dig[k] = 8'hFF;
  endtask

  task automatic model_edge();
    int len = m_q.size();
    bit tk  = m_scroll && ((m_age % TICK_DIV) == TICK_DIV - 1);
    if (btn_clear) begin
      m_q.delete();
      for (int k = 0; k < 4; k++) m_dig[k] = 8'hFF;
      m_scroll = 1'b0;
      m_pos    = 0;
    end else if (btn_load) begin
      if (!m_load_prev && len < MSG_DEPTH) m_q.push_back(~sw);
      m_dig[0] = 8'h47; m_dig[1] = 8'hFF; m_dig[2] = 8'hFF; m_dig[3] = ~sw;
      m_scroll = 1'b0;
      m_pos    = 0;
    end else if (btn_peek) begin
      m_dig[0] = 8'h8F; m_dig[1] = 8'hFF; m_dig[2] = 8'hFF; m_dig[3] = ~sw;
      m_scroll = 1'b0;
      m_pos    = 0;
    end else begin
      for (int k = 1; k <= 4; k++) m_dig[k-1] = m_char(k);
      if (len >= 5) begin
        if (m_scroll) begin
          m_age++;
          if (tk) m_pos = (m_pos + 1) % (len + 1);
        end else begin
          m_age = 0;
        end
        m_scroll = 1'b1;
      end else begin
        m_scroll = 1'b0;
        m_pos    = 0;
      end
    end
    m_load_prev = btn_load;
  endtask

  task automatic compare_all();
    check("dig1", dig1, m_dig[0]);
    check("dig2", dig2, m_dig[1]);
    check("dig3", dig3, m_dig[2]);
    check("dig4", dig4, m_dig[3]);
    check("msg_len", msg_len, m_q.size());
    check("full", full, m_q.size() == MSG_DEPTH);
    check("scrolling", scrolling, m_scroll);
  endtask

  // One clock: model advances on the edge, DUT compared on the following falling edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    else       model_reset();
    @(negedge clk);
    compare_all();
  endtask

  task automatic press(input logic [7:0] v, input int hold);
    btn_load = 1'b1;
    sw       = v;
    repeat (hold) step();
    btn_load = 1'b0;
    step();
  endtask

  task automatic do_clear();
    btn_clear = 1'b1;
    step();
    btn_clear = 1'b0;
    step();
  endtask

  logic [7:0] ch6 [6];
  string      wins [8];

  function automatic logic [31:0] win_val(input int w);
    logic [31:0] r;
    byte         c;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      c = wins[w][k];
      r[31-8*k -: 8] = (c == 8'h5F) ? 8'hFF : ch6[c - 8'h41];
    end
    return r;
  endfunction

  initial begin
    logic [31:0] cur, prev;
    int          w, last;

    wins = '{"ABCD", "BCDE", "CDEF", "DEF_", "EF_A", "F_AB", "_ABC", "ABCD"};
    for (int i = 0; i < 6; i++) ch6[i] = 8'hA0 + 8'(i);

    rst_n = 1'b0; btn_load = 1'b0; btn_peek = 1'b0; btn_clear = 1'b0; sw = 8'h00;
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("reset_digits", {dig1, dig2, dig3, dig4}, 32'hFFFF_FFFF);
    check("reset_len", msg_len, 0);

    // Three short loads, then right-aligned static text.
    btn_load = 1'b1; sw = 8'h01;
    step();
    check("preview_dig1", dig1, 8'h47);
    check("preview_dig4", dig4, 8'hFE);
    sw = 8'h5A;
    step();
    check("preview_live", dig4, 8'hA5);
    btn_load = 1'b0;
    step();
    press(8'h02, 2);
    press(8'h03, 1);
    check("static_3", {dig1, dig2, dig3, dig4}, 32'hFFFE_FDFC);

    // Six characters scroll circularly with a blank gap.
    do_clear();
    for (int i = 0; i < 6; i++) press(~ch6[i], 1);
    prev = '0; w = 0; last = 0;
    for (int c = 0; c < 60 && w < 8; c++) begin
      step();
      cur = {dig1, dig2, dig3, dig4};
      if (scrolling && cur !== prev) begin
        check("window", cur, win_val(w));
        if (w >= 2) check("tick_period", 32'(c - last), 4);
        last = c;
        w++;
      end
      prev = cur;
    end
    check("window_count", 32'(w), 8);

    // Fill to capacity; the 21st press is ignored.
    do_clear();
    for (int i = 0; i < 20; i++) press(~(8'h30 + 8'(i)), 1);
    check("len_at_depth", msg_len, 20);
    check("full_at_depth", full, 1);
    press(8'h00, 2);
    check("len_after_extra", msg_len, 20);
    check("buf0_intact", dig1, 8'h30);
    repeat (10) step();

    // Clear and load edge together while scrolling: clear wins.
    btn_clear = 1'b1; btn_load = 1'b1; sw = 8'h55;
    step();
    check("clear_wins_len", msg_len, 0);
    check("clear_wins_dig", {dig1, dig2, dig3, dig4}, 32'hFFFF_FFFF);
    btn_clear = 1'b0; btn_load = 1'b0;
    step();
    btn_peek = 1'b1; sw = 8'h0F;
    step();
    check("peek_dig1", dig1, 8'h8F);
    check("peek_dig4", dig4, 8'hF0);
    btn_peek = 1'b0;
    step();

    // Asynchronous reset mid-scroll.
    for (int i = 0; i < 6; i++) press(8'(i * 7), 1);
    repeat (9) step();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dig", {dig1, dig2, dig3, dig4}, 32'hFFFF_FFFF);
    check("async_rst_len", msg_len, 0);
    check("async_rst_scroll", scrolling, 0);
    step();
    rst_n = 1'b1;
    step();

    // Asynchronous reset mid-press; level held through reset stores once after release.
    btn_load = 1'b1; sw = 8'hC3;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("press_rst_len", msg_len, 0);
    check("press_rst_dig1", dig1, 8'hFF);
    step();
    rst_n = 1'b1;
    step();
    check("held_load_store", msg_len, 1);
    step();
    btn_load = 1'b0;
    step();

    // Random button activity.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 99) < 8) btn_load = ~btn_load;
      if ($urandom_range(0, 99) < 5) btn_peek = ~btn_peek;
      if (btn_clear) begin
        if ($urandom_range(0, 3) == 0) btn_clear = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        btn_clear = 1'b1;
      end
      sw = 8'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
